// File: rtl/dmem_pkg.sv
// Shared types and defaults for the RISC SPM data-memory port.
// Contents: FSM state encoding, default data/address widths, wait counter width,
// and the even-parity helper used when DMEM_PARITY_EN is defined.
package dmem_pkg;

    localparam int unsigned DMEM_DATA_W = 8;
    localparam int unsigned DMEM_ADDR_W = 8;
    localparam int unsigned DMEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } dmem_state_t;

    // Bit that makes data plus parity contain an even number of ones.
    function automatic logic even_parity(input logic [DMEM_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Data storage for data_mem_port: synchronous write, registered read port.
// Ports:
//   clk, rst_n   clock, async active-low reset (read register only; array not reset)
//   i_wr_en      write i_wdata to i_addr on this edge
//   i_rd_en      capture word at i_addr into o_rdata on this edge
//   i_addr       word address
//   i_wdata      store data
//   o_rdata      last read word, holds between reads
//   o_par_err    one-cycle pulse with a read whose stored parity mismatches
// Optional feature macro: DMEM_PARITY_EN adds a parity column and check.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DMEM_DATA_W,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_par_err
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage columns are intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

`ifdef DMEM_PARITY_EN
    logic r_par [DEPTH];
    logic r_par_err;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_par[i_addr] <= even_parity(i_wdata);
        end
    end

    // Flag is raised in the same cycle the read data becomes visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= i_rd_en && (even_parity(r_mem[i_addr]) != r_par[i_addr]);
        end
    end

    assign o_par_err = r_par_err;
`else
    assign o_par_err = 1'b0;
`endif

endmodule

// File: rtl/data_mem_port.sv
// Multi-cycle data-memory port of the 8-bit RISC SPM.
// Accepts one load/store in IDLE, models slow memory with WAIT_STATES extra cycles,
// then pulses mem_ready. Rejected requests (rd+wr collision, address >= DEPTH) pulse mem_err.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   mem_rd, mem_wr      load / store request, sampled only in IDLE
//   mem_addr, mem_wdata address and store data, captured on acceptance
//   mem_rdata           last load result (to write-back mux input 2)
//   mem_busy            high from the cycle after acceptance until ready
//   mem_ready           one-cycle completion pulse
//   mem_err             one-cycle rejection pulse (and parity-error pulse with ready)
// Optional feature macro: DMEM_PARITY_EN (per-word even parity, checked on loads).
module data_mem_port
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W      = DMEM_DATA_W,
    parameter int unsigned ADDR_W      = DMEM_ADDR_W,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_busy,
    output logic              mem_ready,
    output logic              mem_err
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = DMEM_CNT_W;

    dmem_state_t       r_state;
    dmem_state_t       w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_wr;
    logic [AW-1:0]     r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_busy;
    logic              r_ready;
    logic              r_err;

    logic              w_in_range;
    logic              w_accept;
    logic              w_reject;
    logic              w_enter_done;
    logic              w_op_wr;
    logic [AW-1:0]     w_arr_addr;
    logic [DATA_W-1:0] w_arr_wdata;
    logic              w_par_err;

    assign w_in_range = (32'(mem_addr) < DEPTH);

    // Next-state and accept/reject decode.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_rd || mem_wr) begin
                    if ((mem_rd && mem_wr) || !w_in_range) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // With zero wait states the access happens on the accepting edge, before the
    // capture registers are loaded, so the live inputs are forwarded.
    assign w_enter_done = (w_next_state == S_DONE) && (r_state != S_DONE);
    assign w_op_wr      = (r_state == S_IDLE) ? mem_wr : r_is_wr;
    assign w_arr_addr   = (r_state == S_IDLE) ? mem_addr[AW-1:0] : r_addr;
    assign w_arr_wdata  = (r_state == S_IDLE) ? mem_wdata : r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            r_ready <= (w_next_state == S_DONE);
            r_err   <= w_reject;
            if (w_accept) begin
                r_cnt   <= CNT_W'(WAIT_STATES);
                r_is_wr <= mem_wr;
                r_addr  <= mem_addr[AW-1:0];
                r_wdata <= mem_wdata;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_enter_done && w_op_wr),
        .i_rd_en   (w_enter_done && !w_op_wr),
        .i_addr    (w_arr_addr),
        .i_wdata   (w_arr_wdata),
        .o_rdata   (mem_rdata),
        .o_par_err (w_par_err)
    );

    assign mem_busy  = r_busy;
    assign mem_ready = r_ready;
    assign mem_err   = r_err || w_par_err;

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: directed table, reset/abort/back-to-back
// sequences, and randomized accesses against a behavioural memory model.
module tb_data_mem_port;

    localparam int WS    = 2;
    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd, wr;
    logic [7:0] addr, wdata;
    logic [7:0] rdata;
    logic       busy, ready, err;

    logic       rd0, wr0;
    logic [7:0] addr0, wdata0;
    logic [7:0] rdata0;
    logic       busy0, ready0, err0;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [DEPTH];
    logic [7:0] rdata_m;

    always #5 clk = ~clk;

    data_mem_port #(.WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rd(rd), .mem_wr(wr), .mem_addr(addr),
        .mem_wdata(wdata), .mem_rdata(rdata), .mem_busy(busy), .mem_ready(ready),
        .mem_err(err)
    );

    data_mem_port #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_rd(rd0), .mem_wr(wr0), .mem_addr(addr0),
        .mem_wdata(wdata0), .mem_rdata(rdata0), .mem_busy(busy0), .mem_ready(ready0),
        .mem_err(err0)
    );

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       rej;
        logic [7:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One request through the WAIT_STATES=2 port, observed over a fixed window.
    task automatic run_and_check(input string tag, input logic i_rd, input logic i_wr,
                                 input logic [7:0] a, input logic [7:0] d,
                                 input logic rej, input logic perr, input logic [7:0] exp_rd);
        int rdy_cyc, rdy_cnt, err_cyc, err_cnt, busy_cnt;
        rdy_cyc = -1; rdy_cnt = 0; err_cyc = -1; err_cnt = 0; busy_cnt = 0;
        @(negedge clk);
        rd = i_rd; wr = i_wr; addr = a; wdata = d;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0; addr = 8'($urandom); wdata = 8'($urandom);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ready) begin
                if (rdy_cyc < 0) rdy_cyc = k;
                rdy_cnt++;
            end
            if (err) begin
                if (err_cyc < 0) err_cyc = k;
                err_cnt++;
            end
            if (busy) busy_cnt++;
        end
        if (rej) begin
            check({tag, " ready_cnt"}, rdy_cnt, 0);
            check({tag, " err_cycle"}, err_cyc, 1);
            check({tag, " busy_cnt"}, busy_cnt, 0);
        end else begin
            check({tag, " ready_cycle"}, rdy_cyc, WS + 1);
            check({tag, " ready_cnt"}, rdy_cnt, 1);
            check({tag, " busy_cnt"}, busy_cnt, WS + 1);
            check({tag, " err_cycle"}, err_cyc, perr ? WS + 1 : -1);
        end
        if (rej || perr) check({tag, " err_cnt"}, err_cnt, 1);
        check({tag, " rdata"}, int'(rdata), int'(exp_rd));
    endtask

    // Reference behaviour: update model and return expected outcome.
    task automatic model_access(input logic i_rd, input logic i_wr, input logic [7:0] a,
                                input logic [7:0] d, output logic rej);
        rej = (i_rd && i_wr) || (int'(a) >= DEPTH);
        if (!rej) begin
            if (i_wr) mem_m[a[5:0]] = d;
            else      rdata_m = mem_m[a[5:0]];
        end
    endtask

    // Single strobe on the zero-wait-state port.
    task automatic ws0_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        wr0 = 1'b1; addr0 = a; wdata0 = d;
        @(posedge clk);
        #1 wr0 = 1'b0;
        @(negedge clk);
        check("ws0 wr ready", int'(ready0), 1);
        check("ws0 wr busy", int'(busy0), 1);
        @(negedge clk);
        check("ws0 wr ready_drop", int'(ready0), 0);
    endtask

    vec_t vecs[$];

    initial begin
        logic rej;
        rst_n = 1'b0;
        rd = 1'b1; wr = 1'b0; addr = 8'h05; wdata = 8'h00;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        rdata_m = 8'h00;

        // Reset with a live read request.
        repeat (3) @(negedge clk);
        check("reset rdata", int'(rdata), 0);
        check("reset busy", int'(busy), 0);
        check("reset ready", int'(ready), 0);
        check("reset err", int'(err), 0);
        rd = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset busy", int'(busy), 0);
        check("post-reset ready", int'(ready), 0);

        // Directed table.
        vecs.push_back('{1'b0, 1'b1, 8'h05, 8'hA7, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'hA7});
        vecs.push_back('{1'b1, 1'b1, 8'h05, 8'hFF, 1'b1, 8'hA7});
        vecs.push_back('{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'hA7});
        vecs.push_back('{1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 8'hA7});
        vecs.push_back('{1'b0, 1'b1, 8'h3F, 8'h5C, 1'b0, 8'hA7});
        vecs.push_back('{1'b1, 1'b0, 8'h3F, 8'h00, 1'b0, 8'h5C});
        vecs.push_back('{1'b0, 1'b1, 8'h80, 8'h11, 1'b1, 8'h5C});
        vecs.push_back('{1'b1, 1'b0, 8'h3F, 8'h00, 1'b0, 8'h5C});
        vecs.push_back('{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'hA7});
        foreach (vecs[i]) begin
            model_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rej);
            run_and_check($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                          vecs[i].wdata, vecs[i].rej, 1'b0, vecs[i].exp_rdata);
        end

`ifdef DMEM_PARITY_EN
        // Corrupt a stored data bit so its parity no longer matches.
        @(negedge clk);
        dut.u_array.r_mem[5] = dut.u_array.r_mem[5] ^ 8'h01;
        mem_m[5] = 8'hA6;
        rdata_m  = 8'hA6;
        run_and_check("parity", 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b1, 8'hA6);
`endif

        // Abort a store in WAIT; the location must keep its earlier contents.
        run_and_check("abort prep", 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, rdata_m);
        mem_m[16] = 8'h00;
        @(negedge clk);
        wr = 1'b1; addr = 8'h10; wdata = 8'h55;
        @(posedge clk);
        #1 wr = 1'b0;
        @(negedge clk);
        check("abort in wait busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort reset rdata", int'(rdata), 0);
        check("abort reset busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rdata_m = 8'h00;
        run_and_check("abort read", 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00);

        // Zero wait states: single-cycle access and back-to-back loads.
        ws0_write(8'h00, 8'h11);
        ws0_write(8'h3F, 8'h22);
        @(negedge clk);
        rd0 = 1'b1; addr0 = 8'h00;
        @(posedge clk);
        #1 addr0 = 8'h3F;
        @(negedge clk);
        check("ws0 b2b first ready", int'(ready0), 1);
        check("ws0 b2b first rdata", int'(rdata0), 8'h11);
        @(negedge clk);
        check("ws0 b2b gap ready", int'(ready0), 0);
        check("ws0 b2b gap busy", int'(busy0), 0);
        @(negedge clk);
        rd0 = 1'b0;
        check("ws0 b2b second ready", int'(ready0), 1);
        check("ws0 b2b second rdata", int'(rdata0), 8'h22);
        check("ws0 err", int'(err0), 0);

        // Randomized: preload every word, then mixed traffic.
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            model_access(1'b0, 1'b1, 8'(i), d, rej);
            run_and_check($sformatf("pre%0d", i), 1'b0, 1'b1, 8'(i), d, rej, 1'b0, rdata_m);
        end
        for (int i = 0; i < 200; i++) begin
            logic       r_rd, r_wr;
            logic [7:0] a, d;
            int         sel;
            sel = $urandom_range(0, 9);
            r_rd = (sel == 0) || (sel >= 5);
            r_wr = (sel == 0) || (sel >= 1 && sel <= 4);
            a = 8'($urandom_range(0, 79));
            d = 8'($urandom);
            model_access(r_rd, r_wr, a, d, rej);
            run_and_check($sformatf("rnd%0d", i), r_rd, r_wr, a, d, rej, 1'b0, rdata_m);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
